// File: rtl/result_stream_tx_pkg.sv
// Shared defaults and state encoding for the result stream transmitter.
package result_stream_tx_pkg;

    localparam int              DEF_N_POS  = 36;
    localparam int              DEF_DATA_W = 8;
    localparam logic [7:0]      DEF_HEADER = 8'hA5;

    typedef enum logic [1:0] {
        CAPTURE   = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_PAY  = 2'd2,
        SEND_CSUM = 2'd3
    } tx_state_e;

endpackage

// File: rtl/result_frame_buffer.sv
// Per-position result store: synchronous write, combinational read.
module result_frame_buffer #(
    parameter int N_POS  = 36,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [WORD_W-1:0] mem_q [N_POS];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/result_stream_tx.sv
// Captures one frame of two-channel results, then streams header, payload
// and an 8-bit additive checksum over a valid/ready byte interface.
module result_stream_tx
    import result_stream_tx_pkg::*;
#(
    parameter int                N_POS  = DEF_N_POS,
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] HEADER = DEF_HEADER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              overflow
);

    localparam int PW = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int RW = PW + 1;
    localparam logic [PW-1:0] LAST_POS  = PW'(N_POS - 1);
    localparam logic [RW-1:0] LAST_BYTE = RW'(2 * N_POS - 1);

    tx_state_e           state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [RW-1:0]       rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                overflow_q, overflow_d;

    logic                buf_we;
    logic [2*DATA_W-1:0] rd_word;
    logic [DATA_W-1:0]   pay_byte;
    logic                xfer;

    result_frame_buffer #(
        .N_POS  (N_POS),
        .WORD_W (2 * DATA_W),
        .ADDR_W (PW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr_q),
        .wr_data ({in_data_1, in_data_0}),
        .rd_addr (rd_idx_q[RW-1:1]),
        .rd_data (rd_word)
    );

    // Outputs derive only from registered state, so they hold while stalled.
    assign busy     = (state_q != CAPTURE);
    assign tx_valid = busy;
    assign tx_last  = (state_q == SEND_CSUM);
    assign overflow = overflow_q;
    assign xfer     = tx_valid && tx_ready;
    assign pay_byte = rd_idx_q[0] ? rd_word[2*DATA_W-1:DATA_W] : rd_word[DATA_W-1:0];

    always_comb begin
        tx_data = '0;
        case (state_q)
            SEND_HDR:  tx_data = HEADER;
            SEND_PAY:  tx_data = pay_byte;
            SEND_CSUM: tx_data = csum_q;
            default:   tx_data = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_idx_d   = rd_idx_q;
        csum_d     = csum_q;
        overflow_d = overflow_q | (in_valid && busy);
        buf_we     = 1'b0;
        case (state_q)
            CAPTURE: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (wr_ptr_q == LAST_POS) begin
                        wr_ptr_d = '0;
                        state_d  = SEND_HDR;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            SEND_HDR: begin
                if (xfer) begin
                    rd_idx_d = '0;
                    state_d  = SEND_PAY;
                end
            end
            SEND_PAY: begin
                // Accumulate on transfer so the sum is final for the next cycle.
                if (xfer) begin
                    csum_d = csum_q + pay_byte;
                    if (rd_idx_q == LAST_BYTE) begin
                        rd_idx_d = '0;
                        state_d  = SEND_CSUM;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            SEND_CSUM: begin
                if (xfer) begin
                    csum_d  = '0;
                    state_d = CAPTURE;
                end
            end
            default: state_d = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CAPTURE;
            wr_ptr_q   <= '0;
            rd_idx_q   <= '0;
            csum_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_idx_q   <= rd_idx_d;
            csum_q     <= csum_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
